// File: rtl/mdu.sv
`default_nettype none
// ==========================================================================
// mdu : iterative 32-bit multiply/divide unit producing the HI/LO pair
// Rev 1.0 : initial release
// ==========================================================================
module mdu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] c_OP_MTHI = 3'b100;
    localparam logic [2:0] c_OP_MTLO = 3'b101;
    localparam logic [5:0] c_LAST_ITER = 6'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_cnt;
    logic [31:0] r_hw;
    logic [31:0] r_lw;
    logic [31:0] r_mc;
    logic [31:0] r_a;
    logic        r_div;
    logic        r_sgn;
    logic        r_sa;
    logic        r_sb;
    logic        r_bz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_sgn_in;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_msum;
    logic [32:0] w_dshift;
    logic [32:0] w_ddiff;
    logic [63:0] w_prod;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_accept = (r_state == S_IDLE) && start && !op[2];
    assign w_sgn_in = !op[0];
    assign w_mag_a  = (w_sgn_in && a[31]) ? -a : a;
    assign w_mag_b  = (w_sgn_in && b[31]) ? -b : b;

    // Multiply step: conditional add into the upper half, carry retained in bit 32
    assign w_msum   = {1'b0, r_hw} + (r_lw[0] ? {1'b0, r_mc} : 33'd0);
    // Divide step: remainder in r_hw, quotient shifting into r_lw
    assign w_dshift = {r_hw, r_lw[31]};
    assign w_ddiff  = w_dshift - {1'b0, r_mc};

    assign w_prod     = {r_hw, r_lw};
    assign w_prod_fix = (r_sgn && (r_sa ^ r_sb)) ? -w_prod : w_prod;
    assign w_quo_fix  = (r_sgn && (r_sa ^ r_sb)) ? -r_lw : r_lw;
    assign w_rem_fix  = (r_sgn && r_sa) ? -r_hw : r_hw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == c_LAST_ITER) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 6'd0;
            r_hw  <= 32'd0;
            r_lw  <= 32'd0;
            r_mc  <= 32'd0;
            r_a   <= 32'd0;
            r_div <= 1'b0;
            r_sgn <= 1'b0;
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
            r_bz  <= 1'b0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && op == c_OP_MTHI) begin
                        r_hi <= a;
                    end
                    if (start && op == c_OP_MTLO) begin
                        r_lo <= a;
                    end
                    if (w_accept) begin
                        r_cnt <= 6'd0;
                        r_hw  <= 32'd0;
                        r_div <= op[1];
                        r_sgn <= w_sgn_in;
                        r_sa  <= a[31];
                        r_sb  <= b[31];
                        r_bz  <= (b == 32'd0);
                        r_a   <= a;
                        // Divide: dividend shifts out of r_lw; multiply: multiplier does
                        r_lw  <= op[1] ? w_mag_a : w_mag_b;
                        r_mc  <= op[1] ? w_mag_b : w_mag_a;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (r_div) begin
                        if (!w_ddiff[32]) begin
                            r_hw <= w_ddiff[31:0];
                            r_lw <= {r_lw[30:0], 1'b1};
                        end else begin
                            r_hw <= w_dshift[31:0];
                            r_lw <= {r_lw[30:0], 1'b0};
                        end
                    end else begin
                        r_hw <= w_msum[32:1];
                        r_lw <= {w_msum[0], r_lw[31:1]};
                    end
                end
                S_FIX: begin
                    if (!r_div) begin
                        r_hi <= w_prod_fix[63:32];
                        r_lo <= w_prod_fix[31:0];
                    end else if (r_bz) begin
                        r_hi <= r_a;
                        r_lo <= 32'hFFFF_FFFF;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule
`default_nettype wire
